// File: rtl/t_counter_param_if.sv
// Control/status bundle of the parametrised T-flip-flop counter.
// The master drives the count controls; the slave (the counter) returns q, tc and wrap.
interface t_counter_param_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             sat;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up, sat, load, load_val,
    input  q, tc, wrap
  );

  modport slave (
    input  en, up, sat, load, load_val,
    output q, tc, wrap
  );
endinterface

// File: rtl/t_counter_param.sv
// Modulo-MODULUS up/down counter built from per-bit T flip-flops (q_next = q ^ t),
// with enable, parallel load, wrap/saturate mode, terminal count and a wrap pulse.
module t_counter_param #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2 ** WIDTH
) (
  input logic                clk,
  input logic                reset,
  t_counter_param_if.slave   cnt_if
);

  localparam logic [WIDTH-1:0] END_VAL    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_VAL   = {WIDTH{1'b0}};
  localparam bit               FULL_RANGE = (MODULUS == (2 ** WIDTH));

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             wrap_q;
  logic             wrap_d;
  logic [WIDTH-1:0] tog_s;
  logic [WIDTH-1:0] up_tog_s;
  logic [WIDTH-1:0] dn_tog_s;
  logic [WIDTH-1:0] load_clamp_s;
  logic             at_top_s;
  logic             at_bot_s;
  logic             oor_s;

  assign at_top_s = (cnt_q == END_VAL);
  assign at_bot_s = (cnt_q == ZERO_VAL);

  // A full-range counter can never hold an out-of-range value or be loaded with one.
  generate
    if (FULL_RANGE) begin : g_full
      assign oor_s        = 1'b0;
      assign load_clamp_s = cnt_if.load_val;
    end else begin : g_part
      assign oor_s        = (cnt_q > END_VAL);
      assign load_clamp_s = (cnt_if.load_val > END_VAL) ? END_VAL : cnt_if.load_val;
    end
  endgenerate

  // Ripple toggle terms: bit i toggles when all lower bits are 1 (up) or all 0 (down).
  always_comb begin
    logic [WIDTH-1:0] mask;
    up_tog_s = {WIDTH{1'b0}};
    dn_tog_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      mask        = (WIDTH'(1) << i) - WIDTH'(1);
      up_tog_s[i] = &(cnt_q | ~mask);
      dn_tog_s[i] = &(~cnt_q | ~mask);
    end
  end

  // Toggle vector selection; end values override the ripple terms so non-power-of-two
  // moduli close the cycle (for full range the overrides equal the ripple terms anyway).
  always_comb begin
    tog_s  = {WIDTH{1'b0}};
    wrap_d = 1'b0;
    if (cnt_if.load) begin
      tog_s = cnt_q ^ load_clamp_s;
    end else if (cnt_if.en) begin
      if (oor_s) begin
        tog_s = cnt_q;
      end else if (cnt_if.up) begin
        if (!at_top_s) begin
          tog_s = up_tog_s;
        end else if (cnt_if.sat) begin
          tog_s = {WIDTH{1'b0}};
        end else begin
          tog_s  = cnt_q;
          wrap_d = 1'b1;
        end
      end else begin
        if (!at_bot_s) begin
          tog_s = dn_tog_s;
        end else if (cnt_if.sat) begin
          tog_s = {WIDTH{1'b0}};
        end else begin
          tog_s  = END_VAL;
          wrap_d = 1'b1;
        end
      end
    end else begin
      tog_s = {WIDTH{1'b0}};
    end
    cnt_d = cnt_q ^ tog_s;
  end

  // Count register and wrap flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= {WIDTH{1'b0}};
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt_if.q    = cnt_q;
  assign cnt_if.wrap = wrap_q;
  assign cnt_if.tc   = cnt_if.en & ((cnt_if.up & at_top_s) | (~cnt_if.up & at_bot_s));

endmodule

// File: tb/tb_t_counter_param.sv
// Bench for t_counter_param: a 3-bit modulo-6 and a 4-bit modulo-16 instance share the
// same control inputs; an arithmetic model is compared every cycle, plus directed literals.
module tb_t_counter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_v = 1'b1;
  logic ld_v  = 1'b0;
  logic en_v  = 1'b0;
  logic up_v  = 1'b1;
  logic sat_v = 1'b0;
  int   lv_v  = 0;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  t_counter_param_if #(.WIDTH(3)) if3 ();
  t_counter_param_if #(.WIDTH(4)) if4 ();

  assign if3.en = en_v;  assign if3.up = up_v;  assign if3.sat = sat_v;
  assign if3.load = ld_v;  assign if3.load_val = 3'(lv_v);
  assign if4.en = en_v;  assign if4.up = up_v;  assign if4.sat = sat_v;
  assign if4.load = ld_v;  assign if4.load_val = 4'(lv_v);

  t_counter_param #(.WIDTH(3), .MODULUS(6))  dut3 (.clk(clk), .reset(rst_v), .cnt_if(if3.slave));
  t_counter_param #(.WIDTH(4), .MODULUS(16)) dut4 (.clk(clk), .reset(rst_v), .cnt_if(if4.slave));

  // Behavioural model: plain integer arithmetic on the count.
  function automatic int next_q(input int m, input int q, input bit r, ld, input int lv,
                                input bit e, u, s);
    if (r) return 0;
    if (ld) return (lv >= m) ? m - 1 : lv;
    if (!e) return q;
    if (q >= m) return 0;
    if (u) return (q < m - 1) ? q + 1 : (s ? q : 0);
    return (q > 0) ? q - 1 : (s ? q : m - 1);
  endfunction

  function automatic bit next_w(input int m, input int q, input bit r, ld, e, u, s);
    if (r || ld || !e || s || q >= m) return 1'b0;
    return u ? (q == m - 1) : (q == 0);
  endfunction

  function automatic bit model_tc(input int m, input int q, input bit e, u);
    return e && ((u && q == m - 1) || (!u && q == 0));
  endfunction

  int m3 = 0, m4 = 0;
  bit mw3 = 1'b0, mw4 = 1'b0;

  always @(posedge clk) begin
    m3  <= next_q(6,  m3, rst_v, ld_v, lv_v, en_v, up_v, sat_v);
    mw3 <= next_w(6,  m3, rst_v, ld_v, en_v, up_v, sat_v);
    m4  <= next_q(16, m4, rst_v, ld_v, lv_v, en_v, up_v, sat_v);
    mw4 <= next_w(16, m4, rst_v, ld_v, en_v, up_v, sat_v);
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model q3",    int'(if3.q),    m3);
      chk("model wrap3", int'(if3.wrap), int'(mw3));
      chk("model tc3",   int'(if3.tc),   int'(model_tc(6, m3, en_v, up_v)));
      chk("model q4",    int'(if4.q),    m4);
      chk("model wrap4", int'(if4.wrap), int'(mw4));
      chk("model tc4",   int'(if4.tc),   int'(model_tc(16, m4, en_v, up_v)));
    end
  end

  // One clock: apply inputs, let the edge happen, return shortly after it.
  task automatic cyc(input bit r, ld, input int lv, input bit e, u, s);
    rst_v = r; ld_v = ld; lv_v = lv; en_v = e; up_v = u; sat_v = s;
    @(posedge clk);
    #2;
  endtask

  int up_q[8]  = '{1, 2, 3, 4, 5, 0, 1, 2};
  int up_w[8]  = '{0, 0, 0, 0, 0, 1, 0, 0};
  int up_tc[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
  int dn_q[3]  = '{0, 5, 4};
  int dn_w[3]  = '{0, 1, 0};
  int dn_tc[3] = '{1, 0, 0};

  initial begin
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk_on = 1'b1;
    cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("reset q3", int'(if3.q), 0);
    chk("reset wrap3", int'(if3.wrap), 0);
    chk("reset tc3 down", int'(if3.tc), 1);

    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
      chk("up q3", int'(if3.q), up_q[i]);
      chk("up wrap3", int'(if3.wrap), up_w[i]);
      chk("up tc3", int'(if3.tc), up_tc[i]);
    end

    cyc(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("down to 1", int'(if3.q), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
      chk("down q3", int'(if3.q), dn_q[i]);
      chk("down wrap3", int'(if3.wrap), dn_w[i]);
      chk("down tc3", int'(if3.tc), dn_tc[i]);
    end

    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1);
      chk("sat q3", int'(if3.q), 5);
      chk("sat wrap3", int'(if3.wrap), 0);
      chk("sat tc3", int'(if3.tc), 1);
    end
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
    chk("sat rev q3", int'(if3.q), 4);
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
    chk("sat rev q3", int'(if3.q), 3);

    cyc(1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b0);
    chk("load 3", int'(if3.q), 3);
    chk("load wrap3", int'(if3.wrap), 0);
    cyc(1'b0, 1'b1, 7, 1'b1, 1'b1, 1'b0);
    chk("load clamp", int'(if3.q), 5);
    chk("load 7 wide", int'(if4.q), 7);
    cyc(1'b1, 1'b1, 5, 1'b1, 1'b1, 1'b0);
    chk("reset over load", int'(if3.q), 0);

    cyc(1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    chk("en 1", int'(if3.q), 3);
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("en 0", int'(if3.q), 3);
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    chk("en 1 again", int'(if3.q), 4);
    cyc(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    chk("mid reset q3", int'(if3.q), 0);
    chk("mid reset wrap3", int'(if3.wrap), 0);

    cyc(1'b0, 1'b1, 5, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    chk("wrap before reset", int'(if3.wrap), 1);
    cyc(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    chk("reset clears wrap", int'(if3.wrap), 0);

    for (int i = 0; i < 17; i++) begin
      cyc(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
      chk("pow2 up q4", int'(if4.q), (i + 1) % 16);
      chk("pow2 up wrap4", int'(if4.wrap), (i == 15) ? 1 : 0);
    end
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("pow2 down q4", int'(if4.q), 0);
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("pow2 down q4", int'(if4.q), 15);
    chk("pow2 down wrap4", int'(if4.wrap), 1);

    cyc(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/t_counter_param.md
# t_counter_param

Parametrised synchronous counter built from per-bit T flip-flops. It generalises the fixed 3-bit up counter to any width and modulus, and adds:
- run-time up/down direction
- count enable
- synchronous parallel load
- wrap or saturate mode
- terminal-count and wrap indications

It is the counter primitive for the `sayicilar` counter family, used wherever a modulo-N or bidirectional count is needed.

## Interface
- `WIDTH`, 4: counter width in bits; 1 ≤ WIDTH ≤ 16.
- `MODULUS`, 2**WIDTH: number of count states, 0..MODULUS-1; 2 ≤ MODULUS ≤ 2**WIDTH.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `en` input 1: count enable.
- `up` input 1: direction; 1 = increment, 0 = decrement.
- `sat` input 1: 1 = saturate at the end value, 0 = wrap modulo MODULUS.
- `load` input 1: synchronous parallel load.
- `load_val` input WIDTH: value to load.
- `q` output WIDTH: current count.
- `tc` output 1: terminal count, combinational.
- `wrap` output 1: registered one-cycle wrap pulse.

## Operation
- **Datapath:** WIDTH T flip-flops, one per bit of `q`. The next state is produced only by a per-bit toggle vector `t[WIDTH-1:0]`, where `q_next = q ^ t`. No adder drives the register.
- **Toggle rules, power-of-two modulus, counting up:**
  - `t[0] = 1`
  - `t[i] = &q[i-1:0]`
- **Toggle rules, power-of-two modulus, counting down:**
  - `t[0] = 1`
  - `t[i] = &~q[i-1:0]`
- **Non-power-of-two modulus:** the toggle vector is overridden at the end values.
  - Up, at MODULUS-1, `t = q` (result 0).
  - Down, at 0, `t = MODULUS-1` (result MODULUS-1).
- **Priority per rising edge:** reset > load > en.
  - `reset`=1: `q` ← 0, `wrap` ← 0.
  - `load`=1: `q` ← `load_val`. If `load_val` ≥ MODULUS, `q` ← MODULUS-1. `wrap` ← 0. `en`, `up` and `sat` are ignored.
  - `en`=1, `up`=1:
    - `q` < MODULUS-1: `q` ← `q`+1.
    - `q` = MODULUS-1 and `sat`=0: `q` ← 0, `wrap` ← 1.
    - `q` = MODULUS-1 and `sat`=1: hold, `wrap` ← 0.
  - `en`=1, `up`=0:
    - `q` > 0: `q` ← `q`-1.
    - `q` = 0 and `sat`=0: `q` ← MODULUS-1, `wrap` ← 1.
    - `q` = 0 and `sat`=1: hold, `wrap` ← 0.
  - `en`=0: hold, `wrap` ← 0.
- **`tc`:** `tc = en & ((up & q==MODULUS-1) | (~up & q==0))`. It is independent of `sat` and `load`, so it can cascade into the `en` of a following stage.
- **Out-of-range state:** if `q` ≥ MODULUS (unreachable except through a corrupted state), the next enabled count in either direction gives 0.
- **No FSM beyond the count register:** the `wrap` flag is the only other state.

## Timing
- **Reset values:** `q` = 0 and `wrap` = 0 from the first rising edge with `reset`=1. `tc` follows the inputs combinationally, so it is 1 during reset if `en`=1 and `up`=0.
- **Latency:** `q` and `wrap` are 1 cycle after the controlling edge. `tc` has zero latency from `q`, `en` and `up`.
- **`wrap` pulse:** high for exactly the cycle in which `q` first shows the wrapped value. Back-to-back wraps, e.g. MODULUS=2 counting continuously, keep `wrap` high on consecutive cycles.
- **Reset mid-count:** the count is lost and `q` = 0 on the next edge, regardless of `load` and `en`.
- **Load and count in the same cycle:** load wins; no count, no wrap.
- **Direction change:** `up` is sampled every edge. Reversing direction takes effect on the same edge with no dead cycle.
- **Inputs:** all are synchronous to `clk`. No internal synchronisers.

## Test plan
All scenarios use WIDTH=3, MODULUS=6 unless stated.
- **Reset then count up:** reset 2 cycles, then `en`=1, `up`=1, `sat`=0 for 8 cycles → `q` = 1,2,3,4,5,0,1,2. `wrap`=1 only while `q`=0 after 5. `tc`=1 only while `q`=5.
- **Count down with wrap:** from `q`=1, `en`=1, `up`=0 → `q` = 0,5,4. `wrap`=1 in the cycle `q`=5. `tc`=1 while `q`=0.
- **Saturation:** `sat`=1, `up`=1 from `q`=4 for 4 cycles → `q` = 5,5,5,5, `wrap` stays 0, `tc`=1. Then `up`=0 → `q` = 4,3.
- **Load priority and clamp:** `load`=1, `load_val`=3, `en`=1 → `q`=3, `wrap`=0. `load_val`=7 → `q`=5. `reset`=1 together with `load`=1 → `q`=0.
- **Enable gating and mid-count reset:** `en` toggled 1,0,1 from `q`=2 → `q` = 3,3,4. Then `reset` pulsed for 1 cycle while `q`=4 → `q`=0, `wrap`=0.
- **Power-of-two build, WIDTH=4, MODULUS=16:** up 17 cycles from 0 → `q` = 1..15,0,1 with `wrap` at 0. Then a down run confirms 15 after 0.
